x_clkdiv_lock: RTL and testbench
================================

X_CLKDIV_LOCK -- requirements
Module: x_clkdiv_lock

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of divided-clock channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, width of each channel divide value.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16, CLKIN cycles from reset release to lock (1..65535).
REQ-004 SHALL have parameter DEF_DIV, default 2, divide value loaded into every channel at reset.
REQ-005 SHALL have port CLKIN, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port RSTN, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port SYNC, input, 1, single-cycle request to realign all channels.
REQ-008 SHALL have port DIV_WE, input, 1, divide-value write strobe.
REQ-009 SHALL have port DIV_SEL, input, max(1,clog2(NUM_CH)), target channel of write.
REQ-010 SHALL have port DIV_VAL, input, DIV_W, new divide value.
REQ-011 SHALL have port DIV_ACK, output, 1, one-cycle pulse when a write takes effect.
REQ-012 SHALL have port CLKDV, output, NUM_CH, registered divided clocks.
REQ-013 SHALL have port CLKDV_CE, output, NUM_CH, one-cycle enable per divided period.
REQ-014 SHALL have port LOCKED, output, 1, high only while all channels run aligned.

Function
REQ-015 SHALL implement states STARTUP, ALIGN, RUN; STARTUP entered on reset.
REQ-016 STARTUP SHALL count CLKIN edges after RSTN deassertion; on edge LOCK_CYCLES it SHALL enter RUN.
REQ-017 RUN SHALL enter ALIGN on SYNC=1; ALIGN SHALL last exactly one cycle, then enter RUN; SYNC in STARTUP or ALIGN SHALL be ignored.
REQ-018 LOCKED SHALL be a registered output equal to 1 exactly while state is RUN.
REQ-019 In STARTUP and ALIGN every channel counter SHALL hold 0 and CLKDV, CLKDV_CE SHALL be 0.
REQ-020 Effective divide N SHALL be DIV_VAL stored, with stored values 0 or 1 treated as 2.
REQ-021 In RUN each channel counter SHALL count 0..N-1 and wrap to 0; edge entering RUN loads 0 in all channels.
REQ-022 CLKDV[i] SHALL be 1 when channel counter < (N>>1), else 0 (50% duty for even N; high N>>1 of N cycles for odd N).
REQ-023 CLKDV_CE[i] SHALL be 1 in the cycle whose counter equals N-1.
REQ-024 Write in STARTUP SHALL update divide register immediately; DIV_ACK SHALL pulse the following cycle.
REQ-025 Write in RUN SHALL be held in one pending shadow slot and applied when target counter wraps N-1->0, so no runt pulse; DIV_ACK SHALL pulse on that edge.
REQ-026 Write during ALIGN, or pending write when ALIGN occurs, SHALL be applied at the ALIGN edge with DIV_ACK in the same cycle.
REQ-027 DIV_WE while a write is pending or acked this cycle SHALL be dropped with no DIV_ACK.
REQ-028 DIV_SEL >= NUM_CH SHALL change nothing and SHALL still pulse DIV_ACK next cycle.
REQ-029 Channel writes SHALL NOT affect LOCKED or other channels.

Reset
REQ-030 RSTN=0 SHALL asynchronously force state STARTUP, LOCKED=0, CLKDV=0, CLKDV_CE=0, DIV_ACK=0, counters 0, pending slot empty, all divide registers DEF_DIV.
REQ-031 RSTN assertion mid-RUN SHALL take effect without a CLKIN edge; lock counting SHALL restart from 0 on release.

Verification
REQ-032 Reset release, defaults -> LOCKED rises on 16th CLKIN edge; same edge all CLKDV=1; period 2, CE every 2 cycles.
REQ-033 RUN, write ch1=5 -> DIV_ACK at ch1 next wrap; then CLKDV[1] high 2 of 5 cycles, CE every 5; ch0,2,3 and LOCKED unchanged.
REQ-034 Write ch2=0 then ch3=1 -> both channels behave as N=2.
REQ-035 ch0=3, ch2=4, SYNC pulse -> LOCKED low exactly 1 cycle; all counters restart together, CLKDV rising edges coincident.
REQ-036 Second DIV_WE while write pending -> dropped, single DIV_ACK; NUM_CH=3, DIV_SEL=3 -> no change, DIV_ACK next cycle.
REQ-037 RSTN low mid-RUN between edges -> all outputs 0 immediately, divisors back to 2, relock after 16 edges.

Source files
------------

// File: rtl/x_clkdiv_lock.sv
// Lock-gated multi-channel clock divider: registered outputs, new divide values take effect only at a counter wrap.
// One cycle from input to output; no backpressure, so a write arriving while one is pending or just acked is dropped.
module x_clkdiv_lock #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEF_DIV     = 2,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLKIN,
    input  logic              RSTN,
    input  logic              SYNC,
    input  logic              DIV_WE,
    input  logic [SEL_W-1:0]  DIV_SEL,
    input  logic [DIV_W-1:0]  DIV_VAL,
    output logic              DIV_ACK,
    output logic [NUM_CH-1:0] CLKDV,
    output logic [NUM_CH-1:0] CLKDV_CE,
    output logic              LOCKED
);
    typedef enum logic [1:0] {STARTUP = 2'd0, ALIGN = 2'd1, RUN = 2'd2} state_t;

    localparam logic [15:0]      LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0] DEF_VAL   = DIV_W'(DEF_DIV);

    // Stored values 0 and 1 cannot produce a clock, so they run as divide-by-2.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    state_t                   state_q, state_d;
    logic [15:0]              lock_q, lock_d;
    logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic                     pend_q, pend_d;
    logic [SEL_W-1:0]         psel_q, psel_d;
    logic [DIV_W-1:0]         pval_q, pval_d;
    logic                     ack_q, ack_d, locked_q, locked_d;
    logic [NUM_CH-1:0]        clkdv_q, clkdv_d, ce_q, ce_d;
    logic [NUM_CH-1:0]        sel_hit, psel_hit, wrap;
    logic                     wr_ok, sel_ok;

    always_comb begin
        sel_hit  = '0;
        psel_hit = '0;
        wrap     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_hit[i]  = ({1'b0, DIV_SEL} == (SEL_W + 1)'(i));
            psel_hit[i] = ({1'b0, psel_q} == (SEL_W + 1)'(i));
            wrap[i]     = (cnt_q[i] == eff_div(div_q[i]) - DIV_W'(1));
        end
    end

    assign wr_ok  = DIV_WE && !pend_q && !ack_q;
    assign sel_ok = |sel_hit;

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        psel_d   = psel_q;
        pval_d   = pval_q;
        ack_d    = 1'b0;
        clkdv_d  = '0;
        ce_d     = '0;
        locked_d = 1'b0;

        case (state_q)
            STARTUP: begin
                lock_d = lock_q + 16'd1;
                if (lock_q == LOCK_LAST) state_d = RUN;
                if (wr_ok) begin
                    ack_d = 1'b1;
                    for (int i = 0; i < NUM_CH; i++)
                        if (sel_hit[i]) div_d[i] = DIV_VAL;
                end
            end
            ALIGN: begin
                state_d = RUN;
                if (pend_q) begin
                    ack_d  = 1'b1;
                    pend_d = 1'b0;
                    for (int i = 0; i < NUM_CH; i++)
                        if (psel_hit[i]) div_d[i] = pval_q;
                end else if (wr_ok) begin
                    ack_d = 1'b1;
                    for (int i = 0; i < NUM_CH; i++)
                        if (sel_hit[i]) div_d[i] = DIV_VAL;
                end
            end
            RUN: begin
                if (SYNC) state_d = ALIGN;
                // Applying only at the target's wrap keeps every period whole.
                for (int i = 0; i < NUM_CH; i++) begin
                    if (pend_q && psel_hit[i] && wrap[i]) begin
                        div_d[i] = pval_q;
                        ack_d    = 1'b1;
                        pend_d   = 1'b0;
                    end
                end
                if (wr_ok) begin
                    if (sel_ok) begin
                        pend_d = 1'b1;
                        psel_d = DIV_SEL;
                        pval_d = DIV_VAL;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            default: state_d = STARTUP;
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            if (state_d == RUN && state_q == RUN && !wrap[i]) cnt_d[i] = cnt_q[i] + DIV_W'(1);
            else                                             cnt_d[i] = '0;
            if (state_d == RUN) begin
                clkdv_d[i] = (cnt_d[i] < (eff_div(div_d[i]) >> 1));
                ce_d[i]    = (cnt_d[i] == eff_div(div_d[i]) - DIV_W'(1));
            end
        end
        locked_d = (state_d == RUN);
    end

    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= STARTUP;
            lock_q   <= '0;
            cnt_q    <= '0;
            div_q    <= {NUM_CH{DEF_VAL}};
            pend_q   <= 1'b0;
            psel_q   <= '0;
            pval_q   <= '0;
            ack_q    <= 1'b0;
            clkdv_q  <= '0;
            ce_q     <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            psel_q   <= psel_d;
            pval_q   <= pval_d;
            ack_q    <= ack_d;
            clkdv_q  <= clkdv_d;
            ce_q     <= ce_d;
            locked_q <= locked_d;
        end
    end

    assign DIV_ACK  = ack_q;
    assign CLKDV    = clkdv_q;
    assign CLKDV_CE = ce_q;
    assign LOCKED   = locked_q;
endmodule

// File: tb/tb_x_clkdiv_lock.sv
// Bench for x_clkdiv_lock: a 4-channel and a 3-channel instance checked every cycle against a phase-origin model.
module tb_x_clkdiv_lock;
    localparam int LOCK = 16;
    localparam int NEVER = 32'h7fff_ffff;

    logic       CLKIN = 1'b0, RSTN = 1'b0;
    logic       SYNC = 1'b0, DIV_WE = 1'b0;
    logic [1:0] DIV_SEL = '0;
    logic [7:0] DIV_VAL = '0;
    logic       DIV_ACK, LOCKED;
    logic [3:0] CLKDV, CLKDV_CE;
    logic       SYNC3 = 1'b0, DIV_WE3 = 1'b0;
    logic [1:0] DIV_SEL3 = '0;
    logic [7:0] DIV_VAL3 = '0;
    logic       DIV_ACK3, LOCKED3;
    logic [2:0] CLKDV3, CLKDV_CE3;

    x_clkdiv_lock u_dut (
        .CLKIN(CLKIN), .RSTN(RSTN), .SYNC(SYNC), .DIV_WE(DIV_WE), .DIV_SEL(DIV_SEL),
        .DIV_VAL(DIV_VAL), .DIV_ACK(DIV_ACK), .CLKDV(CLKDV), .CLKDV_CE(CLKDV_CE), .LOCKED(LOCKED)
    );
    x_clkdiv_lock #(.NUM_CH(3)) u_dut3 (
        .CLKIN(CLKIN), .RSTN(RSTN), .SYNC(SYNC3), .DIV_WE(DIV_WE3), .DIV_SEL(DIV_SEL3),
        .DIV_VAL(DIV_VAL3), .DIV_ACK(DIV_ACK3), .CLKDV(CLKDV3), .CLKDV_CE(CLKDV_CE3), .LOCKED(LOCKED3)
    );

    always #5 CLKIN = ~CLKIN;

    int cyc = 0;
    always @(posedge CLKIN) cyc++;

    typedef struct {int ch; int at; int n;} upd_t;
    typedef struct {int sel; int val; int n;} vec_t;

    upd_t upd_q[$];
    int   ack_q[$], ack3_q[$];
    int   org[4], nn[4], org3[3], nn3[3];
    bit   m_run = 1'b0;
    int   lk = NEVER, align_c = -100;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    // Expected waveform of each channel is (cycle - origin) mod N, where origin is the lock,
    // realign or divide-change edge.
    logic [3:0] ec, ee;
    logic [2:0] ec3, ee3;
    bit         e_ack, e_ack3, run_now;
    int         k;
    always @(negedge CLKIN) begin
        while (upd_q.size() > 0 && upd_q[0].at == cyc) begin
            org[upd_q[0].ch] = cyc;
            nn[upd_q[0].ch]  = upd_q[0].n;
            void'(upd_q.pop_front());
        end
        if (!m_run && cyc == lk) begin
            m_run = 1'b1;
            for (int i = 0; i < 4; i++) org[i] = cyc;
            for (int i = 0; i < 3; i++) org3[i] = cyc;
        end
        if (cyc == align_c + 1) for (int i = 0; i < 4; i++) org[i] = cyc;
        run_now = m_run && (cyc != align_c);
        ec = '0; ee = '0; ec3 = '0; ee3 = '0;
        if (run_now) for (int i = 0; i < 4; i++) begin
            k = (cyc - org[i]) % nn[i];
            ec[i] = (k < nn[i] / 2);
            ee[i] = (k == nn[i] - 1);
        end
        if (m_run) for (int i = 0; i < 3; i++) begin
            k = (cyc - org3[i]) % nn3[i];
            ec3[i] = (k < nn3[i] / 2);
            ee3[i] = (k == nn3[i] - 1);
        end
        chk("outputs4", {7'd0, LOCKED, CLKDV, CLKDV_CE}, {7'd0, run_now, ec, ee});
        chk("outputs3", {9'd0, LOCKED3, CLKDV3, CLKDV_CE3}, {9'd0, m_run, ec3, ee3});
        e_ack = (ack_q.size() > 0 && ack_q[0] == cyc);
        chk("div_ack4", {15'd0, DIV_ACK}, {15'd0, e_ack});
        if (e_ack) void'(ack_q.pop_front());
        e_ack3 = (ack3_q.size() > 0 && ack3_q[0] == cyc);
        chk("div_ack3", {15'd0, DIV_ACK3}, {15'd0, e_ack3});
        if (e_ack3) void'(ack3_q.pop_front());
    end

    // RUN-mode write: the value lands at the first wrap of the target after the
    // pending slot fills; dup adds a second strobe that must be dropped.
    task automatic wr_run(input int ch, input int val, input bit dup);
        int e, n;
        e = cyc + 2;
        n = (val < 2) ? 2 : val;
        while ((e - org[ch]) % nn[ch] != 0) e++;
        ack_q.push_back(e);
        upd_q.push_back('{ch, e, n});
        DIV_WE = 1'b1; DIV_SEL = 2'(ch); DIV_VAL = 8'(val);
        tick();
        if (dup) begin
            DIV_VAL = 8'(val + 1);
            tick();
        end
        DIV_WE = 1'b0;
        while (cyc <= e) tick();
    endtask

    task automatic measure(input int ch, output int per);
        int t;
        t = 0;
        while (!CLKDV_CE[ch] && t < 20) begin tick(); t++; end
        tick();
        per = 1;
        while (!CLKDV_CE[ch] && per < 20) begin tick(); per++; end
    endtask

    task automatic model_reset();
        m_run = 1'b0; lk = NEVER; align_c = -100;
        for (int i = 0; i < 4; i++) begin nn[i] = 2; org[i] = 0; end
        for (int i = 0; i < 3; i++) begin nn3[i] = 2; org3[i] = 0; end
    endtask

    initial begin
        vec_t vecs[5];
        int   per, s;
        vecs[0] = '{1, 5, 5};
        vecs[1] = '{2, 0, 2};
        vecs[2] = '{3, 1, 2};
        vecs[3] = '{0, 3, 3};
        vecs[4] = '{2, 4, 4};
        model_reset();

        tick();
        chk("reset4", {6'd0, LOCKED, CLKDV, CLKDV_CE, DIV_ACK}, 16'd0);
        chk("reset3", {8'd0, LOCKED3, CLKDV3, CLKDV_CE3, DIV_ACK3}, 16'd0);
        tick();
        RSTN = 1'b1;
        lk = cyc + LOCK;

        // Write during STARTUP takes effect at once; ack the following cycle.
        tick(); tick();
        DIV_WE3 = 1'b1; DIV_SEL3 = 2'd1; DIV_VAL3 = 8'd4;
        ack3_q.push_back(cyc + 1);
        nn3[1] = 4;
        tick();
        DIV_WE3 = 1'b0;
        while (cyc < lk + 6) tick();

        for (int v = 0; v < 5; v++) begin
            wr_run(vecs[v].sel, vecs[v].val, 1'b0);
            measure(vecs[v].sel, per);
            chk("vec_period", 16'(per), 16'(vecs[v].n));
            repeat (6) tick();
        end

        // Realign, with a write landing in the single ALIGN cycle.
        s = cyc;
        SYNC = 1'b1;
        align_c = s + 1;
        tick();
        SYNC = 1'b0;
        DIV_WE = 1'b1; DIV_SEL = 2'd3; DIV_VAL = 8'd3;
        ack_q.push_back(s + 2);
        upd_q.push_back('{3, s + 2, 3});
        tick();
        DIV_WE = 1'b0;
        repeat (14) tick();

        wr_run(1, 6, 1'b1);
        measure(1, per);
        chk("dropped_write_period", 16'(per), 16'd6);

        DIV_WE3 = 1'b1; DIV_SEL3 = 2'd3; DIV_VAL3 = 8'd7;
        ack3_q.push_back(cyc + 1);
        tick();
        DIV_WE3 = 1'b0;
        repeat (8) tick();

        // Reset between edges must clear outputs without a clock edge.
        #2;
        RSTN = 1'b0;
        model_reset();
        #1;
        chk("async_reset4", {6'd0, LOCKED, CLKDV, CLKDV_CE, DIV_ACK}, 16'd0);
        chk("async_reset3", {8'd0, LOCKED3, CLKDV3, CLKDV_CE3, DIV_ACK3}, 16'd0);
        repeat (3) tick();
        RSTN = 1'b1;
        lk = cyc + LOCK;
        repeat (LOCK + 12) tick();

        chk("acks_outstanding", 16'(ack_q.size() + ack3_q.size() + upd_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
